// File: rtl/main_mem_responder_pkg.sv
// main_mem_responder_pkg: shared memory geometry and latency (package mem_defs) for responder and fill FSM
//   MEM_LATENCY    : read latency in cycles, so the fill FSM drain limit is 8 + MEM_LATENCY
//   MEM_ADDR_W     : byte address width
//   MEM_DATA_W     : word width
//   MEM_DEPTH_LOG2 : log2 of words stored
package mem_defs;
    localparam int MEM_LATENCY    = 4;
    localparam int MEM_ADDR_W     = 16;
    localparam int MEM_DATA_W     = 16;
    localparam int MEM_DEPTH_LOG2 = 10;
endpackage

// File: rtl/main_mem_responder_rd_pipe.sv
// mem_rd_pipe: one {valid, data} read-pipeline stage with synchronous active-low reset
//   clk, rst (active low)  : clock and reset
//   valid_i, data_i        : stage input
//   valid_o, data_o        : registered stage output
module mem_rd_pipe
    import mem_defs::*;
#(
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);
    logic              valid_q;
    logic [DATA_W-1:0] data_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end
    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder: pipelined main-memory model answering reads after LATENCY cycles and absorbing writes
//   clk, rst (active low, synchronous)
//   enable, wr, addr, data_in       : one request per cycle, wr selects write over read
//   data_out, data_valid            : read response, data_out holds between responses
//   rd_outstanding                  : reads issued but not yet presented
module main_mem_responder
    import mem_defs::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int DEPTH_LOG2 = MEM_DEPTH_LOG2,
    parameter int LATENCY    = MEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [3:0]        rd_outstanding
);
    logic [DATA_W-1:0]     mem_q [1 << DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  rd_issue;
    logic [LATENCY:0]      vld;
    logic [DATA_W-1:0]     dat [LATENCY+1];
    logic [3:0]            cnt_q, cnt_d;
    logic                  dv_q, dv_d;
    logic [DATA_W-1:0]     dout_q, dout_d;
    assign idx      = addr[DEPTH_LOG2:1];
    assign rd_issue = enable && !wr;
    // Stage 0 captures the array word at issue; the output register below is the final hop,
    // so a read issued at edge N is presented after edge N+LATENCY.
    assign vld[0] = rd_issue;
    assign dat[0] = mem_q[idx];
    for (genvar g = 0; g < LATENCY; g++) begin : g_pipe
        mem_rd_pipe #(.DATA_W(DATA_W)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .valid_i(vld[g]),
            .data_i (dat[g]),
            .valid_o(vld[g+1]),
            .data_o (dat[g+1])
        );
    end
    always_ff @(posedge clk) begin
        if (enable && wr) mem_q[idx] <= data_in;
    end
    always_comb begin
        cnt_d  = cnt_q + {3'b0, rd_issue} - {3'b0, vld[LATENCY]};
        dv_d   = vld[LATENCY];
        dout_d = vld[LATENCY] ? dat[LATENCY] : dout_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            dv_q   <= 1'b0;
            dout_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            dv_q   <= dv_d;
            dout_q <= dout_d;
        end
    end
    assign rd_outstanding = cnt_q;
    assign data_valid     = dv_q;
    assign data_out       = dout_q;
endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
- Main-memory model answering the cache fill FSM's read requests and the cache's write-through writes.
- Accepts one request per cycle, fully pipelined.
- Returns read data exactly LATENCY cycles after issue, qualified by data_valid. This timing matches the fill FSM's 8-request burst plus 4-cycle drain.
- Sits between the I/D cache fill FSMs (via the arbiter) and the backing store.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- DEPTH_LOG2, 10, log2 of words stored; word index = addr[DEPTH_LOG2:1].
- LATENCY, 4, read latency in cycles, legal range 1..8.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous active-low reset: rst low at a rising clk edge resets the block.
- enable  in  1  request strobe.
- wr  in  1  with enable: 1 = write, 0 = read.
- addr  in  ADDR_W  byte address; bit 0 ignored.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  returned read data.
- data_valid  out  1  data_out holds the response to the read issued LATENCY cycles earlier.
- rd_outstanding  out  4  count of reads in flight (0..LATENCY).

Behaviour:
- Reset (rst=0 at edge): all pipeline valid bits cleared, data_out=0, data_valid=0, rd_outstanding=0.
  - Storage contents are NOT reset.
  - Reads in flight are dropped and never returned.
- Read issue: enable=1, wr=0 at edge N.
  - Array is read at issue: data = mem[addr[DEPTH_LOG2:1]], captured into pipeline stage 1 with valid=1.
  - Data shifts one stage per cycle.
  - After edge N+LATENCY: data_valid=1 and data_out=captured word for exactly one cycle.
  - Back-to-back reads on consecutive cycles produce back-to-back data_valid pulses in issue order, with no bubbles.
- Write: enable=1, wr=1 at edge N → mem[index]=data_in after edge N. No response; a bubble (valid=0) enters the pipeline.
- Read-after-write to the same index on a later cycle returns the new data.
- Write and read cannot be simultaneous (single port); wr selects.
- A read issued while earlier reads are in flight is legal, with no stall. The block never back-pressures.
- Idle cycle (enable=0): bubble enters the pipeline.
- When data_valid=0, data_out holds its last value. It is not zeroed, except by reset.
- Address wrap: bits above DEPTH_LOG2 are ignored, so 0x0802 and 0x0002 alias when DEPTH_LOG2=10.
- rd_outstanding, evaluated at each edge:
  - +1 on a read issue.
  - −1 when a valid exits the last stage.
  - Both in the same cycle: unchanged.
  - Never exceeds LATENCY.
- No state machine beyond the shift pipeline. The pipeline is a LATENCY-deep chain of {valid, data} registers.

Decomposition:
- Shared package/header (mem_defs):
  - MEM_LATENCY=4
  - MEM_ADDR_W=16
  - MEM_DATA_W=16
  - MEM_DEPTH_LOG2=10
  - These let the cache fill FSM's drain count be derived from MEM_LATENCY (count limit = 8 + MEM_LATENCY).
- One natural sub-module: mem_rd_pipe, a single {valid, data} stage with sync active-low reset.
  - Instantiated LATENCY times by generate.
  - The top holds the array, the write path, and the rd_outstanding counter.

Test Plan:
- Reset then single read: preload mem[0x0004>>1]=0xBEEF; read addr 0x0004 at edge 0 → data_valid=1, data_out=0xBEEF after edge 4 only; rd_outstanding goes 1,1,1,1,0.
- 8-word burst: preload words 0x10..0x17 with 0xA000+i; reads on 8 consecutive cycles, addr 0x0020..0x002E step 2 → 8 consecutive data_valid pulses after edges 4..11, data 0xA000..0xA007 in order; rd_outstanding peaks at 4.
- Write then read: write 0x1234 to 0x0040 at edge 0, read 0x0040 at edge 1 → data 0x1234 after edge 5; a read at edge 0 instead of the write returns the old value.
- Read snapshot: read 0x0060 (old 0x1111) at edge 0, write 0x2222 to 0x0060 at edge 1 → returned data_out = 0x1111.
- Reset mid-burst: 3 reads issued, rst=0 at edge 2 → data_valid stays 0 for the following 8 cycles, rd_outstanding=0, memory contents unchanged on re-read.
- Alias/wrap: write 0x5A5A to 0x0802, read 0x0002 → 0x5A5A returned after 4 cycles.
